if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; produces the pc/instruction pair that the decode stage consumes as pc_i/inst_i.
- Fetches each 32-bit instruction as four byte reads over the shared 8-bit memory port, little-endian, and assembles it.
- Holds the assembled word in a one-entry output register under downstream stall, and redirects on a taken branch/jump.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall_i  input  1  decode not ready; 1 = output register must hold.
- branch_flag_i  input  1  taken branch/jump redirect; single-cycle pulse.
- branch_target_i  input  32  redirect target pc.
- mem_req_o  output  1  byte read request.
- mem_addr_o  output  32  byte address of request.
- mem_gnt_i  input  1  arbiter grant; request accepted in a cycle with req&gnt.
- mem_rdata_i  input  8  read byte; valid in the cycle after the grant.
- pc_o  output  32  pc of presented instruction.
- inst_o  output  32  presented instruction.
- valid_o  output  1  pc_o/inst_o hold an unconsumed instruction.

Behaviour:
- Reset (rst=0, async):
  - pc <= RESET_PC; state <= S_B0; byte buffer <= 0; pend <= 0.
  - pc_o <= 0; inst_o <= 0; valid_o <= 0.
- States: S_B0, S_B1, S_B2, S_B3 (issue byte k), S_LAST (wait for byte 3), S_HOLD (word assembled, output register busy).
- Requests:
  - mem_req_o = 1 only in S_Bk; mem_addr_o = pc + k (32-bit wrap).
  - In S_LAST and S_HOLD, mem_req_o = 0 and mem_addr_o = pc.
  - S_Bk advances to the next state only on mem_gnt_i; otherwise it stays with the request and address held stable.
  - S_B3 goes to S_LAST on grant.
- Capture:
  - pend <= (mem_req_o & mem_gnt_i); a 2-bit index tracks which byte is pending.
  - When pend = 1, mem_rdata_i is written to buffer[8*idx+7 : 8*idx]. When pend = 0, mem_rdata_i is ignored.
- Transfer rule: the output register is consumed at any edge where valid_o = 1 and stall_i = 0.
- S_LAST (byte 3 captured at this edge):
  - If valid_o = 0 or stall_i = 0: inst_o <= {mem_rdata_i, buffer[23:0]}; pc_o <= pc; valid_o <= 1; pc <= pc+4; go to S_B0.
  - Otherwise: store byte 3 into the buffer and go to S_HOLD.
- S_HOLD: when stall_i = 0, load inst_o/pc_o from buffer/pc, valid_o stays 1, pc <= pc+4, go to S_B0.
- Output register release: if valid_o = 1, stall_i = 0 and no load happens at that edge, valid_o <= 0.
- While stall_i = 1 and valid_o = 1, pc_o/inst_o/valid_o are stable. Background fetch of the next word continues up to S_HOLD.
- Branch (branch_flag_i = 1) has highest priority, above stall and load:
  - pc <= branch_target_i; state <= S_B0; pend <= 0.
  - valid_o <= 0, dropping any unconsumed instruction.
  - A byte granted in the branch cycle is discarded.
  - Target alignment is not checked; bytes are fetched from pc+k as is.
- Latency with grant always high: first request in the cycle after reset release; valid_o rises 5 edges later. Throughput is 1 instruction per 5 cycles.

Test Plan:
- Reset/first fetch:
  - Stimulus: RESET_PC=0, mem bytes 0..3 = 13,05,A0,00, gnt=1.
  - Required: mem_addr_o 0,1,2,3 in consecutive cycles; after the 5th edge valid_o=1, inst_o=32'h00A00513, pc_o=0.
- Grant starvation:
  - Stimulus: gnt=0 for 3 cycles while in S_B1.
  - Required: mem_addr_o holds 1 and mem_req_o=1; inst_o still 32'h00A00513; completion delayed by exactly 3 cycles.
- Stall hold:
  - Stimulus: stall_i=1 for 12 cycles after the first word.
  - Required: pc_o=0 and inst_o stable; FSM parks in S_HOLD with mem_req_o=0.
  - After stall_i drops: pc_o=4 with the word at 4..7 on the same edge; valid_o stays 1.
- Branch mid-fetch:
  - Stimulus: branch_flag_i=1 with target 32'h100 in S_B2, granted that cycle.
  - Required: valid_o=0 next cycle; the following requests go to addresses 100,101,102,103; the stray byte is not merged; pc_o=32'h100.
- Reset mid-operation:
  - Stimulus: rst=0 asserted asynchronously in S_B3 with valid_o=1.
  - Required: valid_o, pc_o and inst_o go to 0 immediately without a clock edge; after release, fetch restarts at RESET_PC.
- PC wrap:
  - Stimulus: branch to 32'hFFFF_FFFE.
  - Required: addresses FFFFFFFE, FFFFFFFF, 0, 1; next pc = 32'h0000_0002.

Source files
------------

// File: rtl/if_fetch_if.sv
// Shared 8-bit memory read port between the fetch stage (master) and the arbiter (slave).
// A request is accepted in a cycle with req & gnt; the read byte returns in the following cycle.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: four little-endian byte reads per word over the shared memory port,
// one-entry output register toward decode, highest-priority branch redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  if_fetch_if.master       mem,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             valid_o
);

  typedef enum logic [2:0] {
    S_B0,
    S_B1,
    S_B2,
    S_B3,
    S_LAST,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic        pend;
  logic [1:0]  idx;

  logic        issue;
  logic [1:0]  byte_sel;
  logic        granted;
  logic        out_free;

  always_comb begin
    issue    = 1'b0;
    byte_sel = 2'd0;
    case (state)
      S_B0: begin issue = 1'b1; byte_sel = 2'd0; end
      S_B1: begin issue = 1'b1; byte_sel = 2'd1; end
      S_B2: begin issue = 1'b1; byte_sel = 2'd2; end
      S_B3: begin issue = 1'b1; byte_sel = 2'd3; end
      default: begin issue = 1'b0; byte_sel = 2'd0; end
    endcase
  end

  assign mem.mem_req_o  = issue;
  assign mem.mem_addr_o = issue ? (pc + {30'd0, byte_sel}) : pc;
  assign granted        = issue & mem.mem_gnt_i;
  // Output register can accept a new word if empty or being consumed at this edge.
  assign out_free       = ~valid_o | ~stall_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      state   <= S_B0;
      buffer  <= '0;
      pend    <= 1'b0;
      idx     <= 2'd0;
      pc_o    <= '0;
      inst_o  <= '0;
      valid_o <= 1'b0;
    end else if (branch_flag_i) begin
      // Redirect drops the in-flight word, any granted byte and the unconsumed output.
      pc      <= branch_target_i;
      state   <= S_B0;
      pend    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      pend <= granted;
      if (granted)
        idx <= byte_sel;
      if (pend)
        buffer[{idx, 3'b000} +: 8] <= mem.mem_rdata_i;

      if (valid_o && !stall_i)
        valid_o <= 1'b0;

      case (state)
        S_B0: if (granted) state <= S_B1;
        S_B1: if (granted) state <= S_B2;
        S_B2: if (granted) state <= S_B3;
        S_B3: if (granted) state <= S_LAST;
        S_LAST: begin
          // Byte 3 arrives this cycle; bypass it straight into the output when possible.
          if (out_free) begin
            inst_o  <= {mem.mem_rdata_i, buffer[23:0]};
            pc_o    <= pc;
            valid_o <= 1'b1;
            pc      <= pc + 32'd4;
            state   <= S_B0;
          end else begin
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_free) begin
            inst_o  <= buffer;
            pc_o    <= pc;
            valid_o <= 1'b1;
            pc      <= pc + 32'd4;
            state   <= S_B0;
          end
        end
        default: state <= S_B0;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized grant/stall/branch traffic,
// checked against a word-level model of the fetch stage and a hashed byte memory.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  if_fetch_if mif ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .mem             (mif.master),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;
  logic [7:0]  salt;

  // Model: pc of the word being fetched, bytes granted so far, and the output register.
  logic [31:0] m_pc;
  int unsigned m_g;
  logic        m_valid;
  logic [31:0] m_pc_o;
  logic [31:0] m_inst;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'd0: h = 8'h13;
      32'd1: h = 8'h05;
      32'd2: h = 8'hA0;
      32'd3: h = 8'h00;
      default: h = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ salt ^ 8'h3C;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_g     = 0;
    m_valid = 1'b0;
    m_pc_o  = '0;
    m_inst  = '0;
  endtask

  // One clock cycle: check request side, predict the edge, advance, check outputs.
  task automatic step();
    logic        granted;
    logic [31:0] gaddr;
    logic        load;
    chk("req", {31'd0, mif.mem_req_o}, {31'd0, (m_g < 4)});
    chk("addr", mif.mem_addr_o, m_pc + ((m_g < 4) ? m_g : 0));
    granted = mif.mem_req_o & mif.mem_gnt_i;
    gaddr   = mif.mem_addr_o;
    if (branch_flag) begin
      m_pc    = branch_target;
      m_g     = 0;
      m_valid = 1'b0;
    end else begin
      load = (m_g == 4) && (!m_valid || !stall);
      if (load) begin
        m_pc_o  = m_pc;
        m_inst  = word_at(m_pc);
        m_pc    = m_pc + 32'd4;
        m_g     = 0;
        m_valid = 1'b1;
      end else begin
        if (m_valid && !stall)
          m_valid = 1'b0;
        if (m_g < 4 && mif.mem_gnt_i)
          m_g++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    mif.mem_rdata_i = granted ? mem_byte(gaddr) : 8'($urandom);
    chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
    chk("pc_o", pc_o, m_pc_o);
    chk("inst_o", inst_o, m_inst);
  endtask

  initial begin
    int unsigned n;
    logic [31:0] wrap_addr [4];
    tests = 0;
    fails = 0;
    salt  = 8'($urandom);
    rst           = 1'b0;
    stall         = 1'b0;
    branch_flag   = 1'b0;
    branch_target = '0;
    mif.mem_gnt_i   = 1'b0;
    mif.mem_rdata_i = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    rst = 1'b1;

    // First fetch with grant always high.
    mif.mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("first_addr", mif.mem_addr_o, 32'(k));
      step();
    end
    step();
    chk("first_valid", {31'd0, valid_o}, 32'd1);
    chk("first_inst", inst_o, 32'h00A00513);
    chk("first_pc", pc_o, 32'd0);

    // Grant starvation while requesting byte 1 of the next word.
    step();
    mif.mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("starve_addr", mif.mem_addr_o, 32'd5);
      chk("starve_req", {31'd0, mif.mem_req_o}, 32'd1);
      chk("starve_inst", inst_o, 32'h00A00513);
      step();
    end
    mif.mem_gnt_i = 1'b1;
    n = 0;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    chk("starve_latency", n, 32'd4);
    chk("starve_pc", pc_o, 32'd4);

    // Stall holds the output while the next word parks.
    stall = 1'b1;
    for (int k = 0; k < 12; k++)
      step();
    chk("stall_parked_req", {31'd0, mif.mem_req_o}, 32'd0);
    chk("stall_pc_held", pc_o, 32'd4);
    stall = 1'b0;
    step();
    chk("stall_release_pc", pc_o, 32'd8);
    chk("stall_release_valid", {31'd0, valid_o}, 32'd1);
    chk("stall_release_inst", inst_o, word_at(32'd8));

    // Randomized grant/stall/branch traffic.
    for (int i = 0; i < 400; i++) begin
      mif.mem_gnt_i = ($urandom_range(3) != 0);
      stall         = ($urandom_range(2) == 0);
      branch_flag   = ($urandom_range(31) == 0);
      branch_target = ($urandom_range(1) == 0) ? 32'($urandom_range(255)) : $urandom;
      step();
    end
    branch_flag = 1'b0;
    stall       = 1'b0;
    mif.mem_gnt_i = 1'b1;

    // Branch while byte 2 is granted.
    n = 0;
    while (m_g != 2 && n < 12) begin
      step();
      n++;
    end
    chk("reach_b2", m_g, 32'd2);
    branch_flag   = 1'b1;
    branch_target = 32'h0000_0100;
    step();
    branch_flag = 1'b0;
    chk("br_valid_drop", {31'd0, valid_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("br_addr", mif.mem_addr_o, 32'h100 + 32'(k));
      step();
    end
    step();
    chk("br_pc", pc_o, 32'h0000_0100);
    chk("br_inst", inst_o, word_at(32'h100));

    // PC wrap across the top of the address space.
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    step();
    branch_flag = 1'b0;
    wrap_addr[0] = 32'hFFFF_FFFE;
    wrap_addr[1] = 32'hFFFF_FFFF;
    wrap_addr[2] = 32'h0000_0000;
    wrap_addr[3] = 32'h0000_0001;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", mif.mem_addr_o, wrap_addr[k]);
      step();
    end
    step();
    chk("wrap_pc", pc_o, 32'hFFFF_FFFE);
    chk("wrap_inst", inst_o, {8'h05, 8'h13, mem_byte(32'hFFFF_FFFF), mem_byte(32'hFFFF_FFFE)});
    chk("wrap_next_addr", mif.mem_addr_o, 32'h0000_0002);

    // Asynchronous reset while requesting byte 3 with a held output.
    stall = 1'b1;
    n = 0;
    while (!(m_g == 3 && m_valid) && n < 12) begin
      step();
      n++;
    end
    chk("reach_b3", m_g, 32'd3);
    rst = 1'b0;
    #2;
    chk("async_valid", {31'd0, valid_o}, 32'd0);
    chk("async_pc_o", pc_o, 32'd0);
    chk("async_inst_o", inst_o, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    stall = 1'b0;
    for (int k = 0; k < 5; k++)
      step();
    chk("restart_inst", inst_o, 32'h00A00513);
    chk("restart_pc", pc_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
